// File: rtl/rdyack_rr_arbiter.sv
// Round-robin arbiter that merges N rdy/ack sources onto one rdy/ack destination.
// A grant is held for up to BURST transfers; the payload mux is external.
module rdyack_rr_arbiter #(
    parameter int N     = 4,
    parameter int BURST = 1,
    parameter int IW    = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  src_rdys,
    output logic [N-1:0]  src_acks,
    output logic          dst_rdy,
    input  logic          dst_ack,
    output logic [N-1:0]  o_gnt_oh,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_busy
);

    localparam int CW = $clog2(BURST) + 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_idx;
    logic [N-1:0]    gnt_oh;
    logic [CW-1:0]   cnt;

    logic            xfer;
    logic            release_now;
    logic [N-1:0]    cand;
    logic [IW-1:0]   nxt_idx;
    logic [IW-1:0]   pick_idle;
    logic [IW-1:0]   pick_rel;

    // First set bit of mask, scanning upward from start and wrapping at N-1.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] mask, input logic [IW-1:0] start);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && mask[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Handshake: a source raises rdy and holds it until it sees its ack; a transfer
    // happens in the cycle where dst_rdy && dst_ack, and the ack goes back the same cycle.
    always_comb begin
        dst_rdy     = (state == BUSY) && src_rdys[gnt_idx];
        xfer        = dst_rdy && dst_ack;
        src_acks    = gnt_oh & {N{xfer}};
        cand        = src_rdys & ~gnt_oh;
        nxt_idx     = IW'((int'(gnt_idx) + 1) % N);
        pick_idle   = pick(src_rdys, ptr);
        pick_rel    = pick(cand, nxt_idx);
        release_now = (xfer && (cnt == CW'(BURST - 1))) || !src_rdys[gnt_idx];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_idx <= '0;
            gnt_oh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|src_rdys) begin
                        gnt_idx <= pick_idle;
                        gnt_oh  <= ONE << pick_idle;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= nxt_idx;
                        cnt <= '0;
                        // The outgoing grant is masked so its still-high rdy cannot re-win.
                        if (|cand) begin
                            gnt_idx <= pick_rel;
                            gnt_oh  <= ONE << pick_rel;
                        end else begin
                            gnt_idx <= '0;
                            gnt_oh  <= '0;
                            state   <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_gnt_oh  = gnt_oh;
    assign o_gnt_idx = gnt_idx;
    assign o_busy    = (state == BUSY);

    a_acks_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(src_acks));
    a_gnt_onehot0:  assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt_oh));
    a_rdy_busy:     assert property (@(posedge i_clk) disable iff (i_rst) dst_rdy |-> o_busy);
    // A granted source may only withdraw rdy once it has been acked in this grant.
    a_drop_legal:   assert property (@(posedge i_clk) disable iff (i_rst)
                                     (o_busy && !src_rdys[gnt_idx]) |-> (cnt != '0));

endmodule

// File: tb/tb_rdyack_rr_arbiter.sv
// Directed bench for rdyack_rr_arbiter: three N=4 instances with BURST of 1, 3 and 4,
// each driven independently, checked cycle by cycle against hand-derived grants.
module tb_rdyack_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [3];
    logic [3:0] rdys [3];
    logic       ack  [3];
    logic [3:0] acks [3];
    logic       drdy [3];
    logic [3:0] goh  [3];
    logic [1:0] gidx [3];
    logic       busy [3];

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];

    rdyack_rr_arbiter #(.N(4), .BURST(1)) u_b1 (
        .i_clk(clk), .i_rst(rst[0]), .src_rdys(rdys[0]), .src_acks(acks[0]),
        .dst_rdy(drdy[0]), .dst_ack(ack[0]), .o_gnt_oh(goh[0]), .o_gnt_idx(gidx[0]),
        .o_busy(busy[0])
    );
    rdyack_rr_arbiter #(.N(4), .BURST(3)) u_b3 (
        .i_clk(clk), .i_rst(rst[1]), .src_rdys(rdys[1]), .src_acks(acks[1]),
        .dst_rdy(drdy[1]), .dst_ack(ack[1]), .o_gnt_oh(goh[1]), .o_gnt_idx(gidx[1]),
        .o_busy(busy[1])
    );
    rdyack_rr_arbiter #(.N(4), .BURST(4)) u_b4 (
        .i_clk(clk), .i_rst(rst[2]), .src_rdys(rdys[2]), .src_acks(acks[2]),
        .dst_rdy(drdy[2]), .dst_ack(ack[2]), .o_gnt_oh(goh[2]), .o_gnt_idx(gidx[2]),
        .o_busy(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input int d, input logic r, input logic [3:0] rv, input logic a);
        @(posedge clk);
        #1;
        rst[d]  = r;
        rdys[d] = rv;
        ack[d]  = a;
    endtask

    // Outputs are sampled on the falling edge.
    task automatic expect_cyc(input int d, input string tag, input logic [1:0] e_idx,
                              input logic [3:0] e_acks, input logic e_rdy, input logic e_busy);
        logic [3:0] e_oh;
        e_oh = e_busy ? (4'b0001 << e_idx) : 4'b0000;
        @(negedge clk);
        check({tag, ".idx"},  32'(gidx[d]), 32'(e_idx));
        check({tag, ".oh"},   32'(goh[d]),  32'(e_oh));
        check({tag, ".acks"}, 32'(acks[d]), 32'(e_acks));
        check({tag, ".rdy"},  32'(drdy[d]), 32'(e_rdy));
        check({tag, ".busy"}, 32'(busy[d]), 32'(e_busy));
    endtask

    task automatic reset_all(input int d, input logic [3:0] rv, input logic a);
        drive(d, 1'b1, rv, a);
        drive(d, 1'b1, rv, a);
        drive(d, 1'b0, rv, a);
    endtask

    logic [1:0] e_g;
    logic [1:0] seq_idx [5];
    logic [3:0] seq_ack [5];
    logic       seq_bsy [5];

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]  = 1'b1;
            rdys[d] = 4'b0000;
            ack[d]  = 1'b0;
        end

        // BURST=1: reset with all sources requesting, then strict rotation with no bubble.
        drive(0, 1'b1, 4'b1111, 1'b1);
        expect_cyc(0, "rst_hold0", 2'd0, 4'b0000, 1'b0, 1'b0);
        drive(0, 1'b1, 4'b1111, 1'b1);
        expect_cyc(0, "rst_hold1", 2'd0, 4'b0000, 1'b0, 1'b0);
        drive(0, 1'b0, 4'b1111, 1'b1);
        expect_cyc(0, "rst_rel", 2'd0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(2'(i % 4));
        for (int i = 0; i < 8; i++) begin
            e_g = exp_q.pop_front();
            drive(0, 1'b0, 4'b1111, 1'b1);
            expect_cyc(0, $sformatf("rot%0d", i), e_g, 4'b0001 << e_g, 1'b1, 1'b1);
        end

        // BURST=3, lone requester 2: three acks, one idle cycle, re-grant.
        seq_idx = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
        seq_ack = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
        seq_bsy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        reset_all(1, 4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b0, 4'b0100, 1'b1);
            expect_cyc(1, $sformatf("b3_%0d", i), seq_idx[i], seq_ack[i], seq_bsy[i], seq_bsy[i]);
        end

        // BURST=4: src1 drops rdy after two transfers, src3 takes over with a fresh count.
        reset_all(2, 4'b1010, 1'b1);
        drive(2, 1'b0, 4'b1010, 1'b1);
        expect_cyc(2, "drop_t0", 2'd1, 4'b0010, 1'b1, 1'b1);
        drive(2, 1'b0, 4'b1010, 1'b1);
        expect_cyc(2, "drop_t1", 2'd1, 4'b0010, 1'b1, 1'b1);
        drive(2, 1'b0, 4'b1000, 1'b1);
        expect_cyc(2, "drop_gap", 2'd1, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b0, 4'b1000, 1'b1);
            expect_cyc(2, $sformatf("src3_t%0d", i), 2'd3, 4'b1000, 1'b1, 1'b1);
        end
        drive(2, 1'b0, 4'b1000, 1'b1);
        expect_cyc(2, "src3_done", 2'd0, 4'b0000, 1'b0, 1'b0);

        // BURST=1: destination stalls five cycles on grant 1, then the ack moves it to 2.
        reset_all(0, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, 4'b0111, 1'b0);
            expect_cyc(0, $sformatf("stall%0d", i), 2'd1, 4'b0000, 1'b1, 1'b1);
        end
        drive(0, 1'b0, 4'b0111, 1'b1);
        expect_cyc(0, "stall_ack", 2'd1, 4'b0010, 1'b1, 1'b1);
        drive(0, 1'b0, 4'b0101, 1'b1);
        expect_cyc(0, "stall_next", 2'd2, 4'b0100, 1'b1, 1'b1);

        // BURST=4: reset lands mid-burst (gnt=3, cnt=1); next scan restarts at 0.
        reset_all(2, 4'b1000, 1'b1);
        drive(2, 1'b0, 4'b1000, 1'b1);
        expect_cyc(2, "mid_t0", 2'd3, 4'b1000, 1'b1, 1'b1);
        drive(2, 1'b1, 4'b1111, 1'b1);
        expect_cyc(2, "mid_t1", 2'd3, 4'b1000, 1'b1, 1'b1);
        drive(2, 1'b0, 4'b1111, 1'b1);
        expect_cyc(2, "mid_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
        drive(2, 1'b0, 4'b1111, 1'b1);
        expect_cyc(2, "mid_regrant", 2'd0, 4'b0001, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
